// File: rtl/my_nios_mem_stream_loader.sv
// my_nios_mem_stream_loader
//
// Purpose:
//   Upstream feeder for the Nios on-chip RAM (2**ADDR_W x 32, byte-enabled,
//   single port). Takes a byte stream (valid/ready), packs it little-endian
//   into 32-bit words and writes them to consecutive word addresses starting
//   at base_addr. The address wraps from the last word back to 0.
//
// Optional feature:
//   LOADER_READBACK_EN - when defined, each written word is read back
//   (READ state) and compared on the following cycle (CHECK state). A
//   mismatch sets the sticky error flag. When undefined, error is tied to 0
//   and m_readdata is ignored.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               one-cycle pulse; starts a load when idle
//   base_addr           first word address (sampled on start)
//   word_count          number of words to load, 0..2**ADDR_W (sampled on start)
//   s_valid/s_data      byte stream input
//   s_ready             byte accepted when s_valid & s_ready
//   m_address           RAM word address
//   m_byteenable        RAM byte enables, always all ones
//   m_chipselect        RAM select
//   m_write             RAM write strobe
//   m_writedata         RAM write data
//   m_readdata          RAM read data, valid the cycle after a read request
//   m_clken             RAM clock enable, constant 1
//   busy                high from the cycle after start until done
//   done                one-cycle completion pulse
//   error               sticky readback-mismatch flag, cleared by start
//   words_written       words written in the current or last load

module my_nios_mem_stream_loader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic                s_valid,
    input  logic [7:0]          s_data,
    output logic                s_ready,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    output logic                m_clken,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     words_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_FINISH
`ifdef LOADER_READBACK_EN
        ,
        S_READ,
        S_CHECK
`endif
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     remain_q;
    logic [1:0]          byte_idx_q;
    logic [DATA_W-1:0]   word_q;
    logic                s_ready_q;
    logic [ADDR_W-1:0]   m_address_q;
    logic                m_chipselect_q;
    logic                m_write_q;
    logic [DATA_W-1:0]   m_writedata_q;
    logic                busy_q;
    logic                done_q;
    logic [ADDR_W:0]     words_written_q;

    logic [ADDR_W-1:0]   addr_d;
    logic [ADDR_W:0]     remain_d;
    logic [ADDR_W:0]     words_written_d;
    logic [DATA_W-1:0]   packed_d;
    logic                byte_accept;

    always_comb begin
        addr_d          = addr_q + ADDR_W'(1);   // natural wrap at 2**ADDR_W
        remain_d        = remain_q - (ADDR_W+1)'(1);
        words_written_d = words_written_q + (ADDR_W+1)'(1);
        // The 4th byte is still on s_data when the word is launched.
        packed_d        = {s_data, word_q[23:0]};
        byte_accept     = s_valid & s_ready_q;
    end

`ifdef LOADER_READBACK_EN
    logic error_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            remain_q        <= '0;
            byte_idx_q      <= '0;
            word_q          <= '0;
            s_ready_q       <= 1'b0;
            m_address_q     <= '0;
            m_chipselect_q  <= 1'b0;
            m_write_q       <= 1'b0;
            m_writedata_q   <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            words_written_q <= '0;
`ifdef LOADER_READBACK_EN
            error_q         <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q          <= base_addr;
                        remain_q        <= word_count;
                        words_written_q <= '0;
                        byte_idx_q      <= '0;
                        busy_q          <= 1'b1;
`ifdef LOADER_READBACK_EN
                        error_q         <= 1'b0;
`endif
                        if (word_count == '0) begin
                            state_q <= S_FINISH;
                        end else begin
                            state_q   <= S_FILL;
                            s_ready_q <= 1'b1;
                        end
                    end
                end

                S_FILL: begin
                    if (byte_accept) begin
                        word_q[{byte_idx_q, 3'b000} +: 8] <= s_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            // s_ready drops in the same edge that raises the
                            // write strobe, so they never overlap.
                            s_ready_q      <= 1'b0;
                            m_chipselect_q <= 1'b1;
                            m_write_q      <= 1'b1;
                            m_address_q    <= addr_q;
                            m_writedata_q  <= packed_d;
                            state_q        <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    m_write_q       <= 1'b0;
                    words_written_q <= words_written_d;
                    remain_q        <= remain_d;
                    addr_q          <= addr_d;
`ifdef LOADER_READBACK_EN
                    // Chipselect stays high with write low: read of the same address.
                    state_q <= S_READ;
`else
                    m_chipselect_q <= 1'b0;
                    if (remain_d == '0) begin
                        state_q <= S_FINISH;
                    end else begin
                        state_q   <= S_FILL;
                        s_ready_q <= 1'b1;
                    end
`endif
                end

`ifdef LOADER_READBACK_EN
                S_READ: begin
                    m_chipselect_q <= 1'b0;
                    state_q        <= S_CHECK;
                end

                S_CHECK: begin
                    if (m_readdata != m_writedata_q) begin
                        error_q <= 1'b1;
                    end
                    if (remain_q == '0) begin
                        state_q <= S_FINISH;
                    end else begin
                        state_q   <= S_FILL;
                        s_ready_q <= 1'b1;
                    end
                end
`endif

                S_FINISH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_ready       = s_ready_q;
    assign m_address     = m_address_q;
    assign m_byteenable  = '1;
    assign m_chipselect  = m_chipselect_q;
    assign m_write       = m_write_q;
    assign m_writedata   = m_writedata_q;
    assign m_clken       = 1'b1;
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_written = words_written_q;

`ifdef LOADER_READBACK_EN
    assign error = error_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^m_readdata;
    assign error           = 1'b0;
`endif

endmodule

// File: tb/tb_my_nios_mem_stream_loader.sv
// Directed testbench for my_nios_mem_stream_loader with a small RAM model
// and a write monitor. Readback corruption test only in LOADER_READBACK_EN builds.

module tb_my_nios_mem_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] word_count;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [11:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_clken;
    logic        busy;
    logic        done;
    logic        error;
    logic [12:0] words_written;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] mem [0:4095];
    logic        corrupt_en = 1'b0;
    logic [11:0] corrupt_addr = '0;
    logic [11:0] wr_addr [$];
    logic [31:0] wr_data [$];

    my_nios_mem_stream_loader #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .m_address     (m_address),
        .m_byteenable  (m_byteenable),
        .m_chipselect  (m_chipselect),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_readdata    (m_readdata),
        .m_clken       (m_clken),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, optional corruption of one address on write.
    always @(posedge clk) begin
        if (m_chipselect && m_write) begin
            mem[m_address] <= (corrupt_en && m_address == corrupt_addr)
                              ? (m_writedata ^ 32'h0000_0100) : m_writedata;
        end
        if (m_chipselect && !m_write) begin
            m_readdata <= mem[m_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_chipselect === 1'b1 && m_write === 1'b1) begin
            wr_addr.push_back(m_address);
            wr_data.push_back(m_writedata);
            check("wr_byteenable", 32'(m_byteenable), 32'hF);
            check("wr_no_sready", 32'(s_ready), 32'd0);
        end
    end

    task automatic check_reset_outputs();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_chipselect", 32'(m_chipselect), 32'd0);
        check("rst_write", 32'(m_write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_address", 32'(m_address), 32'd0);
        check("rst_writedata", m_writedata, 32'd0);
        check("rst_words_written", 32'(words_written), 32'd0);
        check("rst_byteenable", 32'(m_byteenable), 32'hF);
        check("rst_clken", 32'(m_clken), 32'd1);
    endtask

    // Called at a negedge; returns at a negedge after the byte was taken.
    task automatic push_byte(input logic [7:0] b);
        int unsigned t = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("push_timeout", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [11:0] base, input logic [12:0] cnt);
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int unsigned t = 0;
        while (done !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        s_valid = 1'b0; s_data = '0;
        @(negedge clk);
        do_reset();

        // 1: basic two-word load
        check_reset_outputs();
        wr_addr.delete(); wr_data.delete();
        pulse_start(12'd0, 13'd2);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_sready", 32'(s_ready), 32'd1);
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        wait_done("t1_done");
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_words", 32'(words_written), 32'd2);
        check("t1_nwr", wr_addr.size(), 32'd2);
        check("t1_a0", 32'(wr_addr[0]), 32'd0);
        check("t1_d0", wr_data[0], 32'h04030201);
        check("t1_a1", 32'(wr_addr[1]), 32'd1);
        check("t1_d1", wr_data[1], 32'h08070605);
        check("t1_error", 32'(error), 32'd0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);

        // 2: address wrap
        wr_addr.delete(); wr_data.delete();
        pulse_start(12'd4095, 13'd2);
        for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i));
        wait_done("t2_done");
        check("t2_nwr", wr_addr.size(), 32'd2);
        check("t2_a0", 32'(wr_addr[0]), 32'd4095);
        check("t2_d0", wr_data[0], 32'hA3A2A1A0);
        check("t2_a1", 32'(wr_addr[1]), 32'd0);
        check("t2_d1", wr_data[1], 32'hA7A6A5A4);

        // 3: zero-word load
        wr_addr.delete(); wr_data.delete();
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'h55;
        pulse_start(12'd7, 13'd0);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_done_early", 32'(done), 32'd0);
        check("t3_sready1", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("t3_done", 32'(done), 32'd1);
        check("t3_busy_low", 32'(busy), 32'd0);
        check("t3_sready2", 32'(s_ready), 32'd0);
        check("t3_words", 32'(words_written), 32'd0);
        @(negedge clk);
        check("t3_done_pulse", 32'(done), 32'd0);
        s_valid = 1'b0;
        check("t3_nwr", wr_addr.size(), 32'd0);

        // 4: stalls on s_valid, start ignored mid-load, extra bytes held off
        wr_addr.delete(); wr_data.delete();
        pulse_start(12'd10, 13'd3);
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            push_byte(8'h10 + 8'(i));
            if (i == 4) begin
                pulse_start(12'd100, 13'd0);
                check("t4_busy_after_start", 32'(busy), 32'd1);
            end
        end
        wait_done("t4_done");
        check("t4_words", 32'(words_written), 32'd3);
        s_valid = 1'b1; s_data = 8'hEE;
        repeat (4) @(negedge clk);
        check("t4_sready_after", 32'(s_ready), 32'd0);
        check("t4_busy_after", 32'(busy), 32'd0);
        s_valid = 1'b0;
        check("t4_nwr", wr_addr.size(), 32'd3);
        check("t4_a0", 32'(wr_addr[0]), 32'd10);
        check("t4_d0", wr_data[0], 32'h13121110);
        check("t4_a1", 32'(wr_addr[1]), 32'd11);
        check("t4_d1", wr_data[1], 32'h17161514);
        check("t4_a2", 32'(wr_addr[2]), 32'd12);
        check("t4_d2", wr_data[2], 32'h1B1A1918);

        // 5: reset mid-load
        wr_addr.delete(); wr_data.delete();
        pulse_start(12'd20, 13'd4);
        for (int i = 0; i < 6; i++) push_byte(8'h21 + 8'(i));
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_nwr", wr_addr.size(), 32'd1);
        check("t5_a0", 32'(wr_addr[0]), 32'd20);
        check("t5_d0", wr_data[0], 32'h24232221);
        check("t5_idle_sready", 32'(s_ready), 32'd0);

`ifdef LOADER_READBACK_EN
        // 6: readback mismatch on word 1
        wr_addr.delete(); wr_data.delete();
        corrupt_en = 1'b1; corrupt_addr = 12'd1;
        pulse_start(12'd0, 13'd3);
        for (int i = 0; i < 12; i++) push_byte(8'h40 + 8'(i));
        wait_done("t6_done");
        check("t6_error", 32'(error), 32'd1);
        check("t6_words", 32'(words_written), 32'd3);
        check("t6_nwr", wr_addr.size(), 32'd3);
        corrupt_en = 1'b0;
        @(negedge clk);
        pulse_start(12'd0, 13'd0);
        check("t6_error_cleared", 32'(error), 32'd0);
        wait_done("t6_done2");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
